rect_plot_scheduler: RTL and testbench

Shares the single pixel write port of the VGA adapter between up to four rectangle-drawing clients: start-screen drawer, game-over drawer, frame eraser and sprite drawer. Each client submits one rectangle-fill job, (x, y, w, h, colour). The block grants jobs round-robin, walks the rectangle one pixel per clock onto the adapter port, and pulses a per-client done. It sits between the game state controller's draw/erase engines and the VGA adapter.

---
 rtl/game_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/rect_plot_scheduler.sv | 172 +++++++++++++++++
 tb/tb_rect_plot_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared screen geometry, job record and scheduler state encoding for the
// game's drawing path.
package game_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [X_W-1:0]      w;
        logic [Y_W-1:0]      h;
        logic [COLOUR_W-1:0] colour;
    } rect_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rect_plot_scheduler.sv
// Shares the VGA adapter pixel port between rectangle-fill clients: round-robin
// grant, one pixel per clock, per-client done pulse.
module rect_plot_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned X_MAX   = SCREEN_W - 1,
    parameter int unsigned Y_MAX   = SCREEN_H - 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*X_W-1:0]       req_w,
    input  logic [NUM_REQ*Y_W-1:0]       req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic                         busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t        state_q, state_d;
    rect_job_t           job_q, job_d, sel_job, pix_job;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [X_W-1:0]      cx_q, cx_d;
    logic [Y_W-1:0]      cy_q, cy_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                accept;
    logic                load;

    logic [X_W:0]        pix_x;
    logic [Y_W:0]        pix_y;
    logic [X_W-1:0]      vga_x_d;
    logic [Y_W-1:0]      vga_y_d;
    logic [COLOUR_W-1:0] vga_colour_d;
    logic                vga_plot_d;
    logic [NUM_REQ-1:0]  req_done_d;
    logic                busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        sel_job.x      = req_x[grant_idx*X_W +: X_W];
        sel_job.y      = req_y[grant_idx*Y_W +: Y_W];
        sel_job.w      = req_w[grant_idx*X_W +: X_W];
        sel_job.h      = req_h[grant_idx*Y_W +: Y_W];
        sel_job.colour = req_colour[grant_idx*COLOUR_W +: COLOUR_W];
    end

    // load marks an edge that presents a new pixel; it is computed from the
    // next counter values so the registered outputs line up with PLOT cycles.
    always_comb begin
        state_d      = state_q;
        job_d        = job_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        pix_job      = job_q;
        load         = 1'b0;
        req_done_d   = '0;
        vga_x_d      = vga_x;
        vga_y_d      = vga_y;
        vga_colour_d = vga_colour;
        vga_plot_d   = 1'b0;
        pix_x        = '0;
        pix_y        = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    job_d   = sel_job;
                    owner_d = grant_idx;
                    cx_d    = '0;
                    cy_d    = '0;
                    if (sel_job.w == '0 || sel_job.h == '0) begin
                        state_d               = DONE;
                        req_done_d[grant_idx] = 1'b1;
                    end else begin
                        state_d = PLOT;
                        pix_job = sel_job;
                        load    = 1'b1;
                    end
                end
            end
            PLOT: begin
                if (cx_q == job_q.w - X_W'(1)) begin
                    if (cy_q == job_q.h - Y_W'(1)) begin
                        state_d             = DONE;
                        req_done_d[owner_q] = 1'b1;
                    end else begin
                        cx_d = '0;
                        cy_d = cy_q + Y_W'(1);
                        load = 1'b1;
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                    load = 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            // One spare bit keeps off-screen pixels from aliasing back on screen.
            pix_x        = {1'b0, pix_job.x} + {1'b0, cx_d};
            pix_y        = {1'b0, pix_job.y} + {1'b0, cy_d};
            vga_x_d      = pix_x[X_W-1:0];
            vga_y_d      = pix_y[Y_W-1:0];
            vga_colour_d = pix_job.colour;
            vga_plot_d   = (pix_x <= (X_W+1)'(X_MAX)) && (pix_y <= (Y_W+1)'(Y_MAX));
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            job_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            req_done   <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            req_done   <= req_done_d;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= vga_colour_d;
            vga_plot   <= vga_plot_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// Randomised bench for rect_plot_scheduler against a queue-of-expected-cycles
// reference model, plus directed reset, round-robin, clipping and fairness cases.
module tb_rect_plot_scheduler;
    import game_pkg::*;

    localparam int NREQ = 4;

    logic                     CLOCK_50;
    logic                     reset;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*X_W-1:0]      req_x;
    logic [NREQ*Y_W-1:0]      req_y;
    logic [NREQ*X_W-1:0]      req_w;
    logic [NREQ*Y_W-1:0]      req_h;
    logic [NREQ*COLOUR_W-1:0] req_colour;
    logic [NREQ-1:0]          req_done;
    logic [X_W-1:0]           vga_x;
    logic [Y_W-1:0]           vga_y;
    logic [COLOUR_W-1:0]      vga_colour;
    logic                     vga_plot;
    logic                     busy;

    rect_plot_scheduler dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_done   (req_done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // One entry per expected post-accept cycle: pixels in row-major order, then done.
    typedef struct {
        bit is_done;
        int owner;
        int x;
        int y;
        bit plot;
        int colour;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   jx[NREQ], jy[NREQ], jw[NREQ], jh[NREQ], jc[NREQ];
    bit   sticky[NREQ];
    int   rr_ptr_m;
    int   acc_client;
    int   n_pass;
    int   n_checks;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic set_job(input int i, input int x, input int y, input int w, input int h,
                           input int c);
        req_x[i*X_W +: X_W]                = X_W'(x);
        req_y[i*Y_W +: Y_W]                = Y_W'(y);
        req_w[i*X_W +: X_W]                = X_W'(w);
        req_h[i*Y_W +: Y_W]                = Y_W'(h);
        req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(c);
        jx[i] = x; jy[i] = y; jw[i] = w; jh[i] = h; jc[i] = c;
    endtask

    task automatic model_cycle();
        exp_t e;
        int   g;
        int   idx;
        logic [NREQ-1:0] exp_ready;
        acc_client = -1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("ready_while_busy", req_ready, 0);
            check_eq("busy_high", busy, 1);
            if (e.is_done) begin
                check_eq("done_pulse", req_done, 1 << e.owner);
                check_eq("plot_in_done", vga_plot, 0);
                rr_ptr_m = (e.owner + 1) % NREQ;
            end else begin
                check_eq("done_in_plot", req_done, 0);
                check_eq("plot_enable", vga_plot, e.plot);
                if (e.plot) begin
                    check_eq("pix_x", vga_x, e.x);
                    check_eq("pix_y", vga_y, e.y);
                    check_eq("pix_colour", vga_colour, e.colour);
                end
            end
        end else begin
            check_eq("busy_idle", busy, 0);
            check_eq("plot_idle", vga_plot, 0);
            check_eq("done_idle", req_done, 0);
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr_ptr_m + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
            check_eq("ready_grant", req_ready, exp_ready);
            if (g >= 0 && !reset) begin
                acc_client = g;
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
                for (int n = 0; n < jw[g] * jh[g]; n++) begin
                    e.is_done = 0;
                    e.owner   = g;
                    e.x       = jx[g] + n % jw[g];
                    e.y       = jy[g] + n / jw[g];
                    e.colour  = jc[g];
                    e.plot    = (e.x <= SCREEN_W - 1) && (e.y <= SCREEN_H - 1);
                    exp_q.push_back(e);
                end
                e.is_done = 1;
                e.owner   = g;
                e.plot    = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step(input bit rst);
        @(negedge CLOCK_50);
        reset = rst;
        model_cycle();
        @(posedge CLOCK_50);
        #1;
        if (rst) begin
            exp_q.delete();
            rr_ptr_m = 0;
        end
        if (acc_client >= 0 && !sticky[acc_client]) req_valid[acc_client] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || req_valid != '0) && n < 400) begin
            step(0);
            n++;
        end
        check_eq("drain_bound", n < 400, 1);
    endtask

    task automatic wait_grants(input int cnt);
        int n;
        n = 0;
        while (grant_log.size() < cnt && n < 80) begin
            step(0);
            n++;
        end
        check_eq("grant_count", grant_log.size() >= cnt, 1);
    endtask

    int rr_exp[5];
    int fair_exp[3];

    initial begin
        rr_exp   = '{0, 1, 2, 3, 0};
        fair_exp = '{1, 3, 1};
        reset = 1'b1;
        req_valid = '0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
        n_pass = 0; n_checks = 0; rr_ptr_m = 0; acc_client = -1;
        for (int i = 0; i < NREQ; i++) begin
            sticky[i] = 0;
            set_job(i, 0, 0, 0, 0, 0);
        end
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("rst_x", vga_x, 0);
        check_eq("rst_y", vga_y, 0);
        check_eq("rst_colour", vga_colour, 0);
        check_eq("rst_plot", vga_plot, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", req_done, 0);
        check_eq("rst_ready", req_ready, 0);

        // Reset during the second PLOT cycle of a 2x2 job.
        set_job(0, 10, 20, 2, 2, 5);
        req_valid[0] = 1'b1;
        step(0);
        step(0);
        step(1);
        check_eq("midrst_x", vga_x, 0);
        check_eq("midrst_y", vga_y, 0);
        check_eq("midrst_colour", vga_colour, 0);
        check_eq("midrst_plot", vga_plot, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", req_done, 0);
        repeat (6) step(0);

        // All four clients hammering 1x1 jobs.
        for (int i = 0; i < NREQ; i++) begin
            set_job(i, i * 10, 5, 1, 1, i + 1);
            sticky[i] = 1;
        end
        req_valid = '1;
        grant_log.delete();
        wait_grants(5);
        for (int k = 0; k < 5; k++)
            if (k < grant_log.size()) check_eq("rr_order", grant_log[k], rr_exp[k]);
        for (int i = 0; i < NREQ; i++) sticky[i] = 0;
        req_valid = '0;
        drain();

        set_job(0, 10, 20, 3, 2, 5);
        req_valid[0] = 1'b1;
        drain();

        set_job(2, 30, 40, 0, 5, 6);
        req_valid[2] = 1'b1;
        drain();

        set_job(1, 158, 119, 4, 2, 7);
        req_valid[1] = 1'b1;
        drain();

        // Client 1 re-requests right after done while client 3 waits.
        set_job(1, 50, 60, 2, 1, 2);
        set_job(3, 70, 80, 1, 1, 4);
        sticky[1] = 1;
        req_valid[1] = 1'b1;
        grant_log.delete();
        wait_grants(1);
        req_valid[3] = 1'b1;
        wait_grants(3);
        for (int k = 0; k < 3; k++)
            if (k < grant_log.size()) check_eq("fair_order", grant_log[k], fair_exp[k]);
        sticky[1] = 0;
        req_valid[1] = 1'b0;
        drain();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            step($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_job(i,
                            ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255)
                                                        : $urandom_range(0, 159),
                            ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127)
                                                        : $urandom_range(0, 119),
                            $urandom_range(0, 5), $urandom_range(0, 4),
                            $urandom_range(0, 7));
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
